// File: rtl/line_memory.sv
// line_memory: main-memory model sitting behind the instruction/data caches.
// Accepts one 128-bit line request at a time and answers after a fixed
// REQ_DELAY + RESP_DELAY latency with a single-cycle ready pulse.
// Optional build macro: LINE_MEMORY_RANGE_CHECK_EN adds addr_err_o and turns
// off wrap-around for word indices at or beyond DEPTH.

package brisc_pkg;
   localparam int MEM_DEPTH        = 8192;
   localparam int MEM_REQ_DELAY    = 5;
   localparam int MEM_RESP_DELAY   = 5;
   localparam int CACHE_LINE_WIDTH = 128;

   // Cache -> Mem line request
   typedef struct packed {
      logic         valid;
      logic         rw;     // 1 = write
      logic [31:0]  addr;
      logic [127:0] data;
   } mem_req_t;

   // Mem -> Cache line response
   typedef struct packed {
      logic         ready;
      logic [31:0]  addr;
      logic [127:0] data;
   } mem_resp_t;
endpackage

module line_memory
   import brisc_pkg::*;
#(
   parameter int DEPTH      = MEM_DEPTH,
   parameter int REQ_DELAY  = MEM_REQ_DELAY,
   parameter int RESP_DELAY = MEM_RESP_DELAY,
   parameter int LINE_W     = CACHE_LINE_WIDTH
) (
   input  logic      clk,
   input  logic      reset,
   input  mem_req_t  mem_req_i,
   output mem_resp_t mem_resp_o,
`ifdef LINE_MEMORY_RANGE_CHECK_EN
   output logic      addr_err_o,
`endif
   output logic      busy_o
);

   localparam int WORDS     = LINE_W / 32;
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int MAX_DELAY = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
   localparam int CNT_W     = $clog2(MAX_DELAY + 1);

   typedef enum logic [2:0] {IDLE, REQ_WAIT, ACCESS, RESP_WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               rw_q;
   logic [31:0]        line_q;
   logic [LINE_W-1:0]  wdata_q;
   logic [LINE_W-1:0]  buf_q;
   logic [LINE_W-1:0]  rd_line;
   logic [LINE_W-1:0]  line_now;
   logic               range_err;
   mem_resp_t          resp_q;
   logic [31:0]        mem [DEPTH];

   // The byte offset within a line never affects which line is addressed.
   logic unused_offset;
   assign unused_offset = ^mem_req_i.addr[3:0];

   // Array index of word k of a line, wrapped modulo DEPTH.
   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] line, input int k);
      logic [31:0] w;
      w = {2'b00, line[31:2]} + 32'(k);
      return IDX_W'(w % 32'(DEPTH));
   endfunction

`ifdef LINE_MEMORY_RANGE_CHECK_EN
   assign range_err = ({2'b00, line_q[31:2]} >= 32'(DEPTH));
`else
   assign range_err = 1'b0;
`endif

   // State register; reset returns to IDLE and abandons any request in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; valid is only looked at in IDLE.
   always_comb begin
      // NOTE: default assigned first so every path drives state_d (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (mem_req_i.valid) state_d = REQ_WAIT;
         REQ_WAIT:  if (cnt_q == '0) state_d = ACCESS;
         ACCESS:    state_d = (RESP_DELAY == 1) ? RESP : RESP_WAIT;
         RESP_WAIT: if (cnt_q <= CNT_W'(1)) state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Array read of the latched line; out-of-range reads return zero.
   always_comb begin
      rd_line = '0;
      if (!range_err) begin
         for (int k = 0; k < WORDS; k++) rd_line[32*k +: 32] = mem[word_idx(line_q, k)];
      end
   end

   // Line presented on entry to RESP: taken straight from the access when
   // RESP follows ACCESS directly, otherwise from the response buffer.
   assign line_now = (state_q == ACCESS) ? (rw_q ? wdata_q : rd_line) : buf_q;

   // Request latch, delay counter, response buffer and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         line_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         resp_q  <= '0;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
         addr_err_o <= 1'b0;
`endif
      end else begin
         resp_q.ready <= 1'b0;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
         addr_err_o <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (mem_req_i.valid) begin
                  rw_q    <= mem_req_i.rw;
                  line_q  <= {mem_req_i.addr[31:4], 4'b0000};
                  wdata_q <= mem_req_i.data;
                  cnt_q   <= CNT_W'(REQ_DELAY - 1);
               end
            end
            REQ_WAIT:  if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            ACCESS: begin
               buf_q <= line_now;
               cnt_q <= CNT_W'(RESP_DELAY - 1);
            end
            RESP_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            default: ;
         endcase
         if (state_d == RESP) begin
            resp_q <= '{ready: 1'b1, addr: line_q, data: line_now};
`ifdef LINE_MEMORY_RANGE_CHECK_EN
            addr_err_o <= range_err;
`endif
         end
      end
   end

   // Array write during the single ACCESS cycle of a write request.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; contents survive reset like real DRAM,
      // and a reset in the ACCESS cycle still suppresses the write.
      if (!reset && state_q == ACCESS && rw_q && !range_err) begin
         for (int k = 0; k < WORDS; k++) mem[word_idx(line_q, k)] <= wdata_q[32*k +: 32];
      end
   end

   assign mem_resp_o = resp_q;
   assign busy_o     = (state_q != IDLE);

endmodule
